// File: rtl/rename_alias_table.sv
// rename_alias_table -- register alias table for a DISP_W-wide rename stage.
//
// Purpose:
//   Tracks, per architectural register, the committed value and the ROB tag
//   of its youngest in-flight producer. Each accepted dispatch group is
//   looked up against the table (with forwarding from older slots of the
//   same group). The results are registered and presented one cycle later
//   with a single-cycle out_valid pulse. R0 always reads as zero and is
//   never renamed.
//
// Optional feature (macro RAT_COMMIT_BYPASS_EN):
//   When defined, a source that would wait on a ROB tag retiring in the same
//   cycle takes the retiring value directly instead (rdy=1).
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   disp_valid/ready  dispatch group handshake (ready = !reset && !flush)
//   disp_rd/rs1/rs2   per-slot register IDs, slot 0 is oldest
//   disp_tag          per-slot allocated ROB tag
//   commit_*          ROB retirement write (rd, tag, value)
//   flush             drop every speculative mapping
//   out_valid         one-cycle pulse after an accepted group
//   out_src_tag/val/rdy  per-source result, source index = slot*2 + (0:rs1, 1:rs2)
//   out_rd, out_tag   registered copy of the group's rd/tag for the ROB
//   busy_count        number of registers currently mapped to a ROB tag

// Resolves one source operand against the table. Forwarding from older
// slots of the same group is computed by the parent and arrives as fwd_*.
module rat_src_lookup #(
  parameter int NUM_REGS = 8,
  parameter int TAG_W    = 3,
  parameter int DATA_W   = 32,
  localparam int RW      = $clog2(NUM_REGS)
) (
  input  logic [RW-1:0]                     rs,
  input  logic                              fwd_hit,
  input  logic [TAG_W-1:0]                  fwd_tag,
  input  logic [NUM_REGS-1:0]               map_valid,
  input  logic [NUM_REGS-1:0][TAG_W-1:0]    map_tag,
  input  logic [NUM_REGS-1:0][DATA_W-1:0]   value,
`ifdef RAT_COMMIT_BYPASS_EN
  input  logic                              commit_valid,
  input  logic [RW-1:0]                     commit_rd,
  input  logic [TAG_W-1:0]                  commit_tag,
  input  logic [DATA_W-1:0]                 commit_value,
`endif
  output logic                              rdy,
  output logic [TAG_W-1:0]                  tag,
  output logic [DATA_W-1:0]                 val
);

  always_comb begin
    rdy = 1'b1;
    tag = '0;
    val = '0;
    if (rs == '0) begin
      // R0 reads as constant zero, always ready.
      rdy = 1'b1;
    end else if (fwd_hit) begin
      // An older slot in this group writes rs: wait on that slot's tag.
      rdy = 1'b0;
      tag = fwd_tag;
    end else if (map_valid[rs]) begin
      rdy = 1'b0;
      tag = map_tag[rs];
`ifdef RAT_COMMIT_BYPASS_EN
      // Producer retiring this very cycle: take its value now.
      if (commit_valid && (commit_rd == rs) && (commit_tag == map_tag[rs])) begin
        rdy = 1'b1;
        val = commit_value;
      end
`endif
    end else begin
      val = value[rs];
    end
  end

endmodule

module rename_alias_table #(
  parameter int NUM_REGS = 8,
  parameter int TAG_W    = 3,
  parameter int DATA_W   = 32,
  parameter int DISP_W   = 2,
  localparam int RW      = $clog2(NUM_REGS),
  localparam int NSRC    = DISP_W * 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          disp_valid,
  output logic                          disp_ready,
  input  logic [DISP_W-1:0][RW-1:0]     disp_rd,
  input  logic [DISP_W-1:0][RW-1:0]     disp_rs1,
  input  logic [DISP_W-1:0][RW-1:0]     disp_rs2,
  input  logic [DISP_W-1:0][TAG_W-1:0]  disp_tag,
  input  logic                          commit_valid,
  input  logic [RW-1:0]                 commit_rd,
  input  logic [TAG_W-1:0]              commit_tag,
  input  logic [DATA_W-1:0]             commit_value,
  input  logic                          flush,
  output logic                          out_valid,
  output logic [NSRC-1:0][TAG_W-1:0]    out_src_tag,
  output logic [NSRC-1:0][DATA_W-1:0]   out_src_val,
  output logic [NSRC-1:0]               out_src_rdy,
  output logic [DISP_W-1:0][RW-1:0]     out_rd,
  output logic [DISP_W-1:0][TAG_W-1:0]  out_tag,
  output logic [RW:0]                   busy_count
);

  // Table state.
  logic [NUM_REGS-1:0][DATA_W-1:0]  value;
  logic [NUM_REGS-1:0][TAG_W-1:0]   map_tag;
  logic [NUM_REGS-1:0]              map_valid;

  // Next-state of the mapping half of the table.
  logic [NUM_REGS-1:0][TAG_W-1:0]   map_tag_nxt;
  logic [NUM_REGS-1:0]              map_valid_nxt;
  logic [NUM_REGS-1:0]              renamed;
  logic [RW:0]                      busy_nxt;

  // Per-source lookup plumbing.
  logic [NSRC-1:0][RW-1:0]          src_rs;
  logic [NSRC-1:0]                  fwd_hit;
  logic [NSRC-1:0][TAG_W-1:0]       fwd_tag;
  logic [NSRC-1:0]                  src_rdy;
  logic [NSRC-1:0][TAG_W-1:0]       src_tag;
  logic [NSRC-1:0][DATA_W-1:0]      src_val;

  logic accept;
  logic commit_wr;

  assign disp_ready = !reset && !flush;
  assign accept     = disp_valid && disp_ready;
  assign commit_wr  = commit_valid && (commit_rd != '0);

  // Flatten sources and find intra-group producers. Slots are scanned
  // oldest first so the youngest older writer of rs overrides.
  always_comb begin
    src_rs  = '0;
    fwd_hit = '0;
    fwd_tag = '0;
    for (int s = 0; s < DISP_W; s++) begin
      src_rs[s*2]   = disp_rs1[s];
      src_rs[s*2+1] = disp_rs2[s];
    end
    for (int s = 0; s < DISP_W; s++) begin
      for (int j = 0; j < 2; j++) begin
        for (int k = 0; k < DISP_W; k++) begin
          if ((k < s) && (disp_rd[k] != '0) && (disp_rd[k] == src_rs[s*2+j])) begin
            fwd_hit[s*2+j] = 1'b1;
            fwd_tag[s*2+j] = disp_tag[k];
          end
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NSRC; gi++) begin : g_src
      rat_src_lookup #(
        .NUM_REGS (NUM_REGS),
        .TAG_W    (TAG_W),
        .DATA_W   (DATA_W)
      ) u_lookup (
        .rs           (src_rs[gi]),
        .fwd_hit      (fwd_hit[gi]),
        .fwd_tag      (fwd_tag[gi]),
        .map_valid    (map_valid),
        .map_tag      (map_tag),
        .value        (value),
`ifdef RAT_COMMIT_BYPASS_EN
        .commit_valid (commit_valid),
        .commit_rd    (commit_rd),
        .commit_tag   (commit_tag),
        .commit_value (commit_value),
`endif
        .rdy          (src_rdy[gi]),
        .tag          (src_tag[gi]),
        .val          (src_val[gi])
      );
    end
  endgenerate

  // Mapping update. A commit only retires a mapping if it still names the
  // retiring tag and nothing in this cycle's group re-renames the register;
  // otherwise a younger producer owns it. Renames apply oldest first so the
  // highest slot wins when several slots share rd.
  always_comb begin
    map_valid_nxt = map_valid;
    map_tag_nxt   = map_tag;
    renamed       = '0;
    busy_nxt      = '0;
    if (accept) begin
      for (int s = 0; s < DISP_W; s++) begin
        if (disp_rd[s] != '0) renamed[disp_rd[s]] = 1'b1;
      end
    end
    if (flush) begin
      map_valid_nxt = '0;
    end else begin
      if (commit_wr && map_valid[commit_rd] && (map_tag[commit_rd] == commit_tag)
          && !renamed[commit_rd]) begin
        map_valid_nxt[commit_rd] = 1'b0;
      end
      if (accept) begin
        for (int s = 0; s < DISP_W; s++) begin
          if (disp_rd[s] != '0) begin
            map_valid_nxt[disp_rd[s]] = 1'b1;
            map_tag_nxt[disp_rd[s]]   = disp_tag[s];
          end
        end
      end
    end
    for (int i = 0; i < NUM_REGS; i++) begin
      busy_nxt = busy_nxt + (RW+1)'(map_valid_nxt[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        value[i] <= DATA_W'(i * 10);
      end
      map_valid   <= '0;
      map_tag     <= '0;
      busy_count  <= '0;
      out_valid   <= 1'b0;
      out_src_tag <= '0;
      out_src_val <= '0;
      out_src_rdy <= '0;
      out_rd      <= '0;
      out_tag     <= '0;
    end else begin
      // Retired values land regardless of flush or mapping state.
      if (commit_wr) value[commit_rd] <= commit_value;
      map_valid  <= map_valid_nxt;
      map_tag    <= map_tag_nxt;
      busy_count <= busy_nxt;
      out_valid  <= accept;
      // Result fields hold between groups.
      if (accept) begin
        out_src_tag <= src_tag;
        out_src_val <= src_val;
        out_src_rdy <= src_rdy;
        out_rd      <= disp_rd;
        out_tag     <= disp_tag;
      end
    end
  end

endmodule

// File: tb/tb_rename_alias_table.sv
module tb_rename_alias_table;
  localparam int NR = 8, TW = 3, DW = 32, DWID = 2, RW = 3, NS = 4;

  logic clk = 1'b0;
  logic reset, disp_valid, disp_ready, commit_valid, flush, out_valid;
  logic [DWID-1:0][RW-1:0] disp_rd, disp_rs1, disp_rs2, out_rd;
  logic [DWID-1:0][TW-1:0] disp_tag, out_tag;
  logic [RW-1:0]           commit_rd;
  logic [TW-1:0]           commit_tag;
  logic [DW-1:0]           commit_value;
  logic [NS-1:0][TW-1:0]   out_src_tag;
  logic [NS-1:0][DW-1:0]   out_src_val;
  logic [NS-1:0]           out_src_rdy;
  logic [RW:0]             busy_count;

  always #5 clk = ~clk;

  rename_alias_table #(.NUM_REGS(NR), .TAG_W(TW), .DATA_W(DW), .DISP_W(DWID)) dut (
    .clk(clk), .reset(reset), .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_rd(disp_rd), .disp_rs1(disp_rs1), .disp_rs2(disp_rs2), .disp_tag(disp_tag),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_tag(commit_tag),
    .commit_value(commit_value), .flush(flush), .out_valid(out_valid),
    .out_src_tag(out_src_tag), .out_src_val(out_src_val), .out_src_rdy(out_src_rdy),
    .out_rd(out_rd), .out_tag(out_tag), .busy_count(busy_count)
  );

  // Expected lookup result; val checked when rdy=1, tag checked when rdy=0.
  typedef struct {
    logic [NS-1:0]           rdy;
    logic [NS-1:0][DW-1:0]   val;
    logic [NS-1:0][TW-1:0]   tag;
    logic [DWID-1:0][RW-1:0] rd;
    logic [DWID-1:0][TW-1:0] tg;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  exp_t mon_e;
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a result.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out_valid actual=1 required=0");
      end else begin
        mon_e = q.pop_front();
        for (int i = 0; i < NS; i++) begin
          chk($sformatf("src%0d_rdy", i), 64'(out_src_rdy[i]), 64'(mon_e.rdy[i]));
          if (mon_e.rdy[i]) chk($sformatf("src%0d_val", i), 64'(out_src_val[i]), 64'(mon_e.val[i]));
          else              chk($sformatf("src%0d_tag", i), 64'(out_src_tag[i]), 64'(mon_e.tag[i]));
        end
        chk("out_rd", 64'(out_rd), 64'(mon_e.rd));
        chk("out_tag", 64'(out_tag), 64'(mon_e.tg));
      end
    end
  end

  task automatic clr();
    disp_valid = 1'b0; disp_rd = '0; disp_rs1 = '0; disp_rs2 = '0; disp_tag = '0;
    commit_valid = 1'b0; commit_rd = '0; commit_tag = '0; commit_value = '0;
    flush = 1'b0;
    for (int i = 0; i < NS; i++) begin
      cur.rdy[i] = 1'b1; cur.val[i] = '0; cur.tag[i] = '0;
    end
  endtask

  task automatic slot(input int s, input int rd, input int rs1, input int rs2, input int tag);
    disp_valid  = 1'b1;
    disp_rd[s]  = RW'(rd);
    disp_rs1[s] = RW'(rs1);
    disp_rs2[s] = RW'(rs2);
    disp_tag[s] = TW'(tag);
  endtask

  task automatic es(input int i, input logic r, input int v, input int t);
    cur.rdy[i] = r; cur.val[i] = DW'(v); cur.tag[i] = TW'(t);
  endtask

  task automatic cmt(input int rd, input int tag, input int v);
    commit_valid = 1'b1; commit_rd = RW'(rd); commit_tag = TW'(tag); commit_value = DW'(v);
  endtask

  // Push expectation for an accepted group, then advance one clock.
  task automatic tick();
    if (disp_valid && !flush && !reset) begin
      cur.rd = disp_rd;
      cur.tg = disp_tag;
      q.push_back(cur);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    clr();
    reset = 1'b1;
    tick(); tick();
    chk("rst_disp_ready", 64'(disp_ready), 0);
    chk("rst_busy", 64'(busy_count), 0);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_out_rd", 64'(out_rd), 0);
    chk("rst_out_tag", 64'(out_tag), 0);
    chk("rst_src_rdy", 64'(out_src_rdy), 0);
    chk("rst_src_tag", 64'(out_src_tag), 0);
    for (int i = 0; i < NS; i++) chk($sformatf("rst_src_val%0d", i), 64'(out_src_val[i]), 0);
    reset = 1'b0;
    #1;
    chk("idle_disp_ready", 64'(disp_ready), 1);

    // Basic lookup of reset values.
    clr(); slot(0, 3, 1, 2, 5); es(0, 1, 10, 0); es(1, 1, 20, 0);
    tick(); chk("busy_t1", 64'(busy_count), 1);

    // Intra-group forward and mapped-source wait.
    clr(); slot(0, 4, 3, 0, 2); slot(1, 5, 4, 3, 3);
    es(0, 0, 0, 5); es(1, 1, 0, 0); es(2, 0, 0, 2); es(3, 0, 0, 5);
    tick(); chk("busy_t2", 64'(busy_count), 3);

    // Both slots rename R6: highest slot's tag must stick.
    clr(); slot(0, 6, 6, 7, 4); slot(1, 6, 6, 1, 7);
    es(0, 1, 60, 0); es(1, 1, 70, 0); es(2, 0, 0, 4); es(3, 1, 10, 0);
    tick(); chk("busy_t3", 64'(busy_count), 4);
    clr(); slot(0, 0, 6, 0, 0); es(0, 0, 0, 7);
    tick(); chk("busy_r6", 64'(busy_count), 4);

    // Matching commit retires R3.
    clr(); cmt(3, 5, 99);
    tick(); chk("busy_cmt3", 64'(busy_count), 3);
    clr(); slot(0, 0, 3, 4, 0); es(0, 1, 99, 0); es(1, 0, 0, 2);
    tick();

    // Stale commit keeps the younger mapping.
    clr(); slot(0, 3, 0, 0, 6);
    tick(); chk("busy_remap", 64'(busy_count), 4);
    clr(); cmt(3, 5, 55);
    tick(); chk("busy_stale", 64'(busy_count), 4);
    clr(); slot(0, 0, 3, 0, 0); es(0, 0, 0, 6);
    tick();

    // Commit matches, but same-cycle rename of R4 wins.
    clr(); cmt(4, 2, 44); slot(0, 4, 0, 0, 1);
    tick(); chk("busy_cmt_ren", 64'(busy_count), 4);
    clr(); slot(0, 0, 4, 5, 0); es(0, 0, 0, 1); es(1, 0, 0, 3);
    tick();

    // Lookup of a source whose producer retires this cycle.
    clr(); cmt(5, 3, 7); slot(0, 0, 5, 0, 0);
`ifdef RAT_COMMIT_BYPASS_EN
    es(0, 1, 7, 0);
`else
    es(0, 0, 0, 3);
`endif
    tick(); chk("busy_bypass", 64'(busy_count), 3);

    // Flush with a pending group and a same-cycle commit.
    clr(); flush = 1'b1; slot(0, 2, 1, 0, 0); cmt(6, 7, 66);
    #1; chk("flush_disp_ready", 64'(disp_ready), 0);
    tick();
    chk("flush_busy", 64'(busy_count), 0);
    chk("flush_out_valid", 64'(out_valid), 0);
    clr(); slot(0, 0, 3, 6, 0); slot(1, 0, 4, 5, 0);
    es(0, 1, 55, 0); es(1, 1, 66, 0); es(2, 1, 44, 0); es(3, 1, 7, 0);
    tick();

    // Reset in mid-group discards the group and restores values.
    clr(); reset = 1'b1; slot(0, 2, 0, 0, 1);
    tick();
    chk("rst2_busy", 64'(busy_count), 0);
    chk("rst2_out_valid", 64'(out_valid), 0);
    reset = 1'b0;
    clr(); slot(0, 0, 3, 2, 0); es(0, 1, 30, 0); es(1, 1, 20, 0);
    tick();

    clr();
    tick(); tick(); tick();
    chk("scoreboard_drained", 64'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
